// File: rtl/hack_arb_pkg.sv
// rtl/hack_arb_pkg.sv - shared types and constants for the Hack data-RAM arbiter
//   req_id_t    : requester identity, also used as the read-response owner tag
//   ADDR_W      : RAM word-address width (32K words)
//   DATA_W      : RAM word width
//   SCR_ADDR_W  : screen-relative address width (8K words)
//   SCREEN_BASE : RAM word address where the screen map starts
package hack_arb_pkg;

  localparam int ADDR_W     = 15;
  localparam int DATA_W     = 16;
  localparam int SCR_ADDR_W = 13;

  localparam logic [ADDR_W-1:0] SCREEN_BASE = 15'h4000;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_CPU  = 2'd1,
    REQ_SCR  = 2'd2,
    REQ_DBG  = 2'd3
  } req_id_t;

endpackage

// File: rtl/hack_arb_age_ctr.sv
// rtl/hack_arb_age_ctr.sv - saturating lost-arbitration counter for one non-CPU requester
//   clk       in  : clock, rising edge
//   reset_n   in  : asynchronous active-low reset
//   valid_i   in  : requester is asking for the RAM this cycle
//   granted_i in  : requester won arbitration this cycle
//   urgent_o  out : requester has lost AGE_LIMIT consecutive cycles and must be served next
module hack_arb_age_ctr #(
  parameter int unsigned AGE_LIMIT = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic valid_i,
  input  logic granted_i,
  output logic urgent_o
);

  localparam logic [7:0] LIMIT = 8'(AGE_LIMIT);

  logic [7:0] count_q;
  logic [7:0] count_d;

  // Count only consecutive losing cycles; any grant or idle cycle restarts aging.
  always_comb begin
    count_d = count_q;
    if (!valid_i || granted_i) begin
      count_d = 8'd0;
    end else if (count_q != LIMIT) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign urgent_o = valid_i && (count_q == LIMIT);

endmodule

// File: rtl/hack_mem_arbiter.sv
// rtl/hack_mem_arbiter.sv - single-port Hack data-RAM arbiter for CPU, screen refresh and debug ports
//   Optional feature macro: HACK_ARB_PERF_EN (grant/conflict performance counters)
//   clk, reset_n                  : clock (rising edge), asynchronous active-low reset
//   cpu_req_* / cpu_rsp_*         : CPU read/write request handshake and read response
//   scr_req_* / scr_rsp_*         : screen read-only request (offset from SCREEN_BASE) and response
//   dbg_req_* / dbg_rsp_*         : host debug/loader read/write request and read response
//   ram_en/ram_we/ram_addr/wdata  : synchronous RAM strobe, write enable, address, write data
//   ram_rdata                     : RAM read data, valid one cycle after a read strobe
//   perf_clear, perf_* (optional) : counter clear and 32-bit grant/conflict counters
module hack_mem_arbiter
  import hack_arb_pkg::*;
#(
  parameter int unsigned AGE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cpu_req_valid,
  output logic                  cpu_req_ready,
  input  logic                  cpu_req_we,
  input  logic [ADDR_W-1:0]     cpu_req_addr,
  input  logic [DATA_W-1:0]     cpu_req_wdata,
  output logic                  cpu_rsp_valid,
  output logic [DATA_W-1:0]     cpu_rsp_data,
  input  logic                  scr_req_valid,
  output logic                  scr_req_ready,
  input  logic [SCR_ADDR_W-1:0] scr_req_addr,
  output logic                  scr_rsp_valid,
  output logic [DATA_W-1:0]     scr_rsp_data,
  input  logic                  dbg_req_valid,
  output logic                  dbg_req_ready,
  input  logic                  dbg_req_we,
  input  logic [ADDR_W-1:0]     dbg_req_addr,
  input  logic [DATA_W-1:0]     dbg_req_wdata,
  output logic                  dbg_rsp_valid,
  output logic [DATA_W-1:0]     dbg_rsp_data,
`ifdef HACK_ARB_PERF_EN
  input  logic                  perf_clear,
  output logic [31:0]           perf_grant_cpu,
  output logic [31:0]           perf_grant_scr,
  output logic [31:0]           perf_grant_dbg,
  output logic [31:0]           perf_conflict,
`endif
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [DATA_W-1:0]     ram_wdata,
  input  logic [DATA_W-1:0]     ram_rdata
);

  req_id_t grant;
  req_id_t owner_q;
  req_id_t owner_d;
  logic    scr_urgent;
  logic    dbg_urgent;

  hack_arb_age_ctr #(.AGE_LIMIT(AGE_LIMIT)) u_scr_age (
    .clk       (clk),
    .reset_n   (reset_n),
    .valid_i   (scr_req_valid),
    .granted_i (grant == REQ_SCR),
    .urgent_o  (scr_urgent)
  );

  hack_arb_age_ctr #(.AGE_LIMIT(AGE_LIMIT)) u_dbg_age (
    .clk       (clk),
    .reset_n   (reset_n),
    .valid_i   (dbg_req_valid),
    .granted_i (grant == REQ_DBG),
    .urgent_o  (dbg_urgent)
  );

  // Reset is folded into the grant so no handshake or RAM strobe leaks out while held.
  always_comb begin
    grant = REQ_NONE;
    if (reset_n) begin
      if (scr_urgent)         grant = REQ_SCR;
      else if (dbg_urgent)    grant = REQ_DBG;
      else if (cpu_req_valid) grant = REQ_CPU;
      else if (scr_req_valid) grant = REQ_SCR;
      else if (dbg_req_valid) grant = REQ_DBG;
    end
  end

  assign cpu_req_ready = (grant == REQ_CPU);
  assign scr_req_ready = (grant == REQ_SCR);
  assign dbg_req_ready = (grant == REQ_DBG);

  always_comb begin
    ram_en    = (grant != REQ_NONE);
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    case (grant)
      REQ_CPU: begin
        ram_we    = cpu_req_we;
        ram_addr  = cpu_req_addr;
        ram_wdata = cpu_req_wdata;
      end
      REQ_SCR: begin
        // 8K offset above 0x4000 tops out at 0x5FFF, so the add never wraps.
        ram_addr = SCREEN_BASE + {{(ADDR_W-SCR_ADDR_W){1'b0}}, scr_req_addr};
      end
      REQ_DBG: begin
        ram_we    = dbg_req_we;
        ram_addr  = dbg_req_addr;
        ram_wdata = dbg_req_wdata;
      end
      default: ;
    endcase
  end

  // Only reads need a response; the owner tag steers next cycle's ram_rdata.
  assign owner_d = (ram_en && !ram_we) ? grant : REQ_NONE;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_q <= REQ_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  assign cpu_rsp_valid = (owner_q == REQ_CPU);
  assign scr_rsp_valid = (owner_q == REQ_SCR);
  assign dbg_rsp_valid = (owner_q == REQ_DBG);
  assign cpu_rsp_data  = cpu_rsp_valid ? ram_rdata : '0;
  assign scr_rsp_data  = scr_rsp_valid ? ram_rdata : '0;
  assign dbg_rsp_data  = dbg_rsp_valid ? ram_rdata : '0;

`ifdef HACK_ARB_PERF_EN
  logic [31:0] perf_cpu_q, perf_scr_q, perf_dbg_q, perf_conf_q;
  logic        conflict;

  assign conflict = (cpu_req_valid && scr_req_valid) || (cpu_req_valid && dbg_req_valid) ||
                    (scr_req_valid && dbg_req_valid);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_cpu_q  <= 32'd0;
      perf_scr_q  <= 32'd0;
      perf_dbg_q  <= 32'd0;
      perf_conf_q <= 32'd0;
    end else if (perf_clear) begin
      perf_cpu_q  <= 32'd0;
      perf_scr_q  <= 32'd0;
      perf_dbg_q  <= 32'd0;
      perf_conf_q <= 32'd0;
    end else begin
      if (grant == REQ_CPU) perf_cpu_q  <= perf_cpu_q + 32'd1;
      if (grant == REQ_SCR) perf_scr_q  <= perf_scr_q + 32'd1;
      if (grant == REQ_DBG) perf_dbg_q  <= perf_dbg_q + 32'd1;
      if (conflict)         perf_conf_q <= perf_conf_q + 32'd1;
    end
  end

  assign perf_grant_cpu = perf_cpu_q;
  assign perf_grant_scr = perf_scr_q;
  assign perf_grant_dbg = perf_dbg_q;
  assign perf_conflict  = perf_conf_q;
`endif

endmodule
